// File: rtl/pc_fetch_unit.sv
// Program counter and fetch-request generator with buffered redirects and exceptions.
// Optional misaligned-target checking is enabled by defining PC_ALIGN_CHECK_EN.
module pc_fetch_unit #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(32'h0000_3000),
  parameter logic [ADDR_W-1:0] HANDLER_PC = ADDR_W'(32'h0000_4180)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              En,
  input  logic [2:0]        sel,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] j_target,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic [ADDR_W-1:0] epc,
  input  logic              exc,
  output logic              req_valid,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              req_ready,
  output logic              adel,
  output logic [ADDR_W-1:0] bad_vaddr
);

  localparam logic [2:0] SEL_ADD4   = 3'd0;
  localparam logic [2:0] SEL_J      = 3'd1;
  localparam logic [2:0] SEL_JR     = 3'd2;
  localparam logic [2:0] SEL_BRANCH = 3'd3;
  localparam logic [2:0] SEL_ERET   = 3'd4;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  logic              pc_v;
  logic [ADDR_W-1:0] pc;
  logic              pend_v;
  logic              pend_exc;
  logic [ADDR_W-1:0] pend_addr;

  logic              fire;
  logic              redirect;
  logic [ADDR_W-1:0] target;
  logic              take_exc;
  logic              apply;
  logic [ADDR_W-1:0] apply_addr;
  logic              misaligned;
  logic [ADDR_W-1:0] next_pc;

  assign pc_v      = En & ~Reset;
  assign req_valid = pc_v;
  assign req_addr  = pc;
  assign fire      = req_valid & req_ready;

  // Jump/branch targets are always word aligned; register targets are only
  // left unmasked when the alignment check is present to trap on them.
  always_comb begin
    redirect = 1'b0;
    target   = '0;
    case (sel)
      SEL_J: begin
        redirect = 1'b1;
        target   = j_target & ALIGN_MASK;
      end
      SEL_JR: begin
        redirect = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
        target   = jr_target;
`else
        target   = jr_target & ALIGN_MASK;
`endif
      end
      SEL_BRANCH: begin
        redirect = branch_taken;
        target   = j_target & ALIGN_MASK;
      end
      SEL_ERET: begin
        redirect = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
        target   = epc;
`else
        target   = epc & ALIGN_MASK;
`endif
      end
      default: begin
        redirect = 1'b0;
        target   = '0;
      end
    endcase
  end

  // A buffered redirect wins over a fresh one; exceptions win over both.
  always_comb begin
    take_exc   = exc | pend_exc;
    apply      = pend_v | redirect;
    apply_addr = pend_v ? pend_addr : target;
`ifdef PC_ALIGN_CHECK_EN
    misaligned = fire & ~take_exc & apply & (apply_addr[1:0] != 2'b00);
`else
    misaligned = 1'b0;
`endif
    if (take_exc || misaligned)
      next_pc = HANDLER_PC;
    else if (apply)
      next_pc = apply_addr;
    else
      next_pc = pc + ADDR_W'(4);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc        <= RESET_PC;
      pend_v    <= 1'b0;
      pend_exc  <= 1'b0;
      pend_addr <= '0;
    end else if (fire) begin
      pc       <= next_pc;
      pend_v   <= 1'b0;
      pend_exc <= 1'b0;
    end else begin
      if (exc)
        pend_exc <= 1'b1;
      if (redirect) begin
        pend_addr <= target;
        pend_v    <= 1'b1;
      end
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      adel      <= 1'b0;
      bad_vaddr <= '0;
    end else begin
      adel <= misaligned;
      if (misaligned)
        bad_vaddr <= apply_addr;
    end
  end
`else
  assign adel      = 1'b0;
  assign bad_vaddr = '0;
`endif

endmodule
